// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: bundles the requester-side handshake and the
// shared-multiplier bus of mul_arbiter.
//   slave  modport: arbiter view (takes requests and multiplier results,
//                   drives ack/valid/product/err/busy and multiplier controls)
//   master modport: environment view (requesters plus shared multiplier)
interface mul_arbiter_if #(
   parameter int DATA_BITS = 32,
   parameter int REQ_NUM   = 4
);
   localparam int RESULT_BITS = 2 * DATA_BITS;

   logic [REQ_NUM-1:0]           req;
   logic [REQ_NUM-1:0]           req_sign;
   logic [REQ_NUM*DATA_BITS-1:0] req_a;
   logic [REQ_NUM*DATA_BITS-1:0] req_b;
   logic [REQ_NUM-1:0]           ack;
   logic [REQ_NUM-1:0]           valid;
   logic [RESULT_BITS-1:0]       product;
   logic                         err;
   logic                         busy;
   logic                         mul_en;
   logic                         mul_sign;
   logic [DATA_BITS-1:0]         mul_cand;
   logic [DATA_BITS-1:0]         mul_plier;
   logic                         mul_done;
   logic [RESULT_BITS-1:0]       mul_product;

   modport slave (
      input  req, req_sign, req_a, req_b, mul_done, mul_product,
      output ack, valid, product, err, busy, mul_en, mul_sign, mul_cand, mul_plier
   );

   modport master (
      output req, req_sign, req_a, req_b, mul_done, mul_product,
      input  ack, valid, product, err, busy, mul_en, mul_sign, mul_cand, mul_plier
   );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one multiplier among REQ_NUM
// requesters. One operation in flight at a time: IDLE picks a winner and
// captures its operands, ISSUE pulses ack/mul_en, WAIT waits for mul_done
// (or aborts after TIMEOUT cycles), RESP pulses valid (with err on abort).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mul_arbiter_if.slave (requests, ack/valid/product/err/busy,
//          shared-multiplier controls and results)
// All outputs are registered; each is computed from the next state so it
// lines up with the state it belongs to.
module mul_arbiter #(
   parameter int DATA_BITS = 32,
   parameter int REQ_NUM   = 4,
   parameter int TIMEOUT   = 255
) (
   input logic          clk,
   input logic          rst_n,
   mul_arbiter_if.slave bus
);
   localparam int RESULT_BITS = 2 * DATA_BITS;
   localparam int IDX_W       = (REQ_NUM > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       gid_q, gid_d;
   logic [DATA_BITS-1:0]   cand_q, cand_d;
   logic [DATA_BITS-1:0]   plier_q, plier_d;
   logic                   sign_q, sign_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   errflag_q, errflag_d;
   logic [RESULT_BITS-1:0] product_q, product_d;
   logic [REQ_NUM-1:0]     ack_q, ack_d;
   logic [REQ_NUM-1:0]     valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic                   mul_en_q, mul_en_d;

   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   int                     scan_j;

   function automatic logic [REQ_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [REQ_NUM-1:0] v;
      v      = {REQ_NUM{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search: first set req bit at or above ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      scan_j    = 0;
      for (int k = 0; k < REQ_NUM; k++) begin
         scan_j = int'(ptr_q) + k;
         if (scan_j >= REQ_NUM) begin
            scan_j = scan_j - REQ_NUM;
         end else begin
            scan_j = scan_j;
         end
         if (!win_found && bus.req[scan_j[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_j[IDX_W-1:0];
         end else begin
            win_found = win_found;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      cand_d    = cand_q;
      plier_d   = plier_q;
      sign_d    = sign_q;
      cnt_d     = cnt_q;
      errflag_d = errflag_q;
      product_d = product_q;
      ack_d     = {REQ_NUM{1'b0}};
      valid_d   = {REQ_NUM{1'b0}};
      err_d     = 1'b0;
      mul_en_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gid_d    = win_idx;
               cand_d   = bus.req_a[win_idx*DATA_BITS +: DATA_BITS];
               plier_d  = bus.req_b[win_idx*DATA_BITS +: DATA_BITS];
               sign_d   = bus.req_sign[win_idx];
               ptr_d    = (win_idx == IDX_W'(REQ_NUM - 1)) ? {IDX_W{1'b0}}
                                                           : win_idx + IDX_W'(1);
               ack_d    = onehot(win_idx);
               mul_en_d = 1'b1;
               state_d  = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = 16'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // mul_done wins over a timeout landing on the same cycle.
            if (bus.mul_done) begin
               product_d = bus.mul_product;
               errflag_d = 1'b0;
               valid_d   = onehot(gid_q);
               err_d     = 1'b0;
               state_d   = ST_RESP;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               errflag_d = 1'b1;
               valid_d   = onehot(gid_q);
               err_d     = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= {IDX_W{1'b0}};
         gid_q     <= {IDX_W{1'b0}};
         cand_q    <= {DATA_BITS{1'b0}};
         plier_q   <= {DATA_BITS{1'b0}};
         sign_q    <= 1'b0;
         cnt_q     <= 16'd0;
         errflag_q <= 1'b0;
         product_q <= {RESULT_BITS{1'b0}};
         ack_q     <= {REQ_NUM{1'b0}};
         valid_q   <= {REQ_NUM{1'b0}};
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         mul_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gid_q     <= gid_d;
         cand_q    <= cand_d;
         plier_q   <= plier_d;
         sign_q    <= sign_d;
         cnt_q     <= cnt_d;
         errflag_q <= errflag_d;
         product_q <= product_d;
         ack_q     <= ack_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         mul_en_q  <= mul_en_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.valid     = valid_q;
   assign bus.product   = product_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
   assign bus.mul_en    = mul_en_q;
   assign bus.mul_sign  = sign_q;
   assign bus.mul_cand  = cand_q;
   assign bus.mul_plier = plier_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed plus randomized bench for mul_arbiter
// (DATA_BITS=32, REQ_NUM=4, TIMEOUT=8). The bench plays the requesters and
// the shared multiplier; a round-robin reference model predicts winners and
// products from plain arithmetic.
module tb_mul_arbiter;
   logic clk;
   logic rst_n;

   mul_arbiter_if #(.DATA_BITS(32), .REQ_NUM(4)) bus ();

   mul_arbiter #(.DATA_BITS(32), .REQ_NUM(4), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp;
   int          n_err;
   int          ptr_m;
   logic [63:0] prod_m;
   logic [31:0] a_m [4];
   logic [31:0] b_m [4];
   logic        s_m [4];

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      if (s) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else   return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string ctx);
      chk({ctx, "_ack"}, 64'(bus.ack), 64'd0);
      chk({ctx, "_valid"}, 64'(bus.valid), 64'd0);
      chk({ctx, "_err"}, 64'(bus.err), 64'd0);
      chk({ctx, "_busy"}, 64'(bus.busy), 64'd0);
      chk({ctx, "_mul_en"}, 64'(bus.mul_en), 64'd0);
      chk({ctx, "_mul_sign"}, 64'(bus.mul_sign), 64'd0);
      chk({ctx, "_mul_cand"}, 64'(bus.mul_cand), 64'd0);
      chk({ctx, "_mul_plier"}, 64'(bus.mul_plier), 64'd0);
      chk({ctx, "_product"}, bus.product, 64'd0);
   endtask

   // Round-robin reference: first set bit at or above ptr_m, wrapping.
   function automatic int pick(input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
      end
      return -1;
   endfunction

   // One full operation starting in an IDLE cycle; lat < 0 means no mul_done.
   task automatic do_op(input logic [3:0] r, input int lat, input bit keep_req);
      int w;
      for (int i = 0; i < 4; i++) begin
         bus.req_a[i*32 +: 32] = a_m[i];
         bus.req_b[i*32 +: 32] = b_m[i];
         bus.req_sign[i]       = s_m[i];
      end
      bus.req = r;
      w       = pick(r);
      ptr_m   = (w + 1) % 4;
      step();
      chk("ack", 64'(bus.ack), 64'(4'b0001 << w));
      chk("mul_en_issue", 64'(bus.mul_en), 64'd1);
      chk("busy_issue", 64'(bus.busy), 64'd1);
      chk("mul_cand", 64'(bus.mul_cand), 64'(a_m[w]));
      chk("mul_plier", 64'(bus.mul_plier), 64'(b_m[w]));
      chk("mul_sign", 64'(bus.mul_sign), 64'(s_m[w]));
      if (!keep_req) begin
         bus.req      = 4'($urandom);
         bus.req_a    = {$urandom, $urandom, $urandom, $urandom};
         bus.req_sign = 4'($urandom);
      end
      step();
      chk("ack_wait", 64'(bus.ack), 64'd0);
      chk("mul_en_wait", 64'(bus.mul_en), 64'd0);
      if (lat >= 0) begin
         repeat (lat) begin
            chk("valid_early", 64'(bus.valid), 64'd0);
            step();
         end
         chk("cand_hold", 64'(bus.mul_cand), 64'(a_m[w]));
         bus.mul_done    = 1'b1;
         bus.mul_product = ref_prod(bus.mul_cand, bus.mul_plier, bus.mul_sign);
         step();
         bus.mul_done    = 1'b0;
         bus.mul_product = {$urandom, $urandom};
         prod_m          = ref_prod(a_m[w], b_m[w], s_m[w]);
         chk("err_done", 64'(bus.err), 64'd0);
      end else begin
         repeat (7) begin
            step();
            chk("valid_timeout_early", 64'(bus.valid), 64'd0);
         end
         step();
         chk("err_timeout", 64'(bus.err), 64'd1);
      end
      chk("valid", 64'(bus.valid), 64'(4'b0001 << w));
      chk("product", bus.product, prod_m);
      if (!keep_req) bus.req = 4'd0;
      step();
      chk("valid_after", 64'(bus.valid), 64'd0);
      chk("err_after", 64'(bus.err), 64'd0);
      chk("busy_idle", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int lat;
      clk             = 1'b0;
      rst_n           = 1'b1;
      n_cmp           = 0;
      n_err           = 0;
      ptr_m           = 0;
      prod_m          = 64'd0;
      bus.req         = 4'hF;
      bus.req_sign    = 4'd0;
      bus.req_a       = 128'd0;
      bus.req_b       = 128'd0;
      bus.mul_done    = 1'b0;
      bus.mul_product = 64'd0;
      for (int i = 0; i < 4; i++) begin
         a_m[i] = 32'(i + 3);
         b_m[i] = 32'(i + 10);
         s_m[i] = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 chk_zero("reset");
      step();
      step();
      chk_zero("reset_held");
      rst_n = 1'b1;

      // Contention: all requests held high from reset -> 0,1,2,3,0.
      do_op(4'hF, 0, 1'b1);
      do_op(4'hF, 1, 1'b1);
      do_op(4'hF, 2, 1'b1);
      do_op(4'hF, 3, 1'b1);
      do_op(4'hF, 7, 1'b1);   // done on the timeout cycle wins
      bus.req = 4'd0;

      // Unsigned operands on requester 0.
      a_m[0] = 32'hFFFF_FFFF; b_m[0] = 32'd2; s_m[0] = 1'b0;
      do_op(4'b0001, 2, 1'b0);
      chk("unsigned_const", bus.product, 64'h0000_0001_FFFF_FFFE);

      // Signed operands on requester 2.
      a_m[2] = 32'hFFFF_FFFD; b_m[2] = 32'd5; s_m[2] = 1'b1;
      do_op(4'b0100, 1, 1'b0);
      chk("signed_const", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);

      // Timeout on requester 3: product keeps the previous result.
      do_op(4'b1000, -1, 1'b0);
      chk("timeout_product", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);

      // Spurious mul_done while idle is ignored.
      bus.mul_done    = 1'b1;
      bus.mul_product = 64'hDEAD_BEEF_0BAD_F00D;
      step();
      bus.mul_done = 1'b0;
      chk("spurious_valid", 64'(bus.valid), 64'd0);
      chk("spurious_busy", 64'(bus.busy), 64'd0);
      step();
      chk("spurious_product", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);
      a_m[1] = 32'd1234; b_m[1] = 32'd5678; s_m[1] = 1'b0;
      do_op(4'b0010, 3, 1'b0);
      chk("spurious_real", bus.product, 64'd7006652);

      // Reset in the middle of WAIT drops the operation and ptr.
      bus.req = 4'b0010;
      step();
      chk("pre_reset_ack", 64'(bus.ack), 64'b0010);
      bus.req = 4'd0;
      step();
      step();
      rst_n = 1'b0;
      #1 chk_zero("midop_reset");
      step();
      chk_zero("midop_reset_held");
      rst_n  = 1'b1;
      ptr_m  = 0;
      prod_m = 64'd0;
      step();
      chk("post_reset_valid", 64'(bus.valid), 64'd0);
      do_op(4'b1010, 2, 1'b0);   // ptr back at 0 -> requester 1

      // Randomized operations against the reference model.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 4; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
            s_m[i] = 1'($urandom);
         end
         lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 7));
         do_op(4'($urandom_range(1, 15)), lat, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
